// File: rtl/arb_pkg.sv
// Shared widths and FSM state encoding for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : arb_pkg

// File: rtl/arbiter8_rr_if.sv
// Request/grant bundle between the requesting lanes (master) and the arbiter (slave).
interface arbiter8_rr_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             busy;
  logic             timeout;

  modport master (output req, input gnt, gnt_idx, busy, timeout);
  modport slave  (input req, output gnt, gnt_idx, busy, timeout);

endinterface : arbiter8_rr_if

// File: rtl/rr_pick8.sv
// Combinational rotating priority encoder: first set request at or after ptr, modulo 8.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]   w_off;

  // Doubling the vector turns the rotate-right into a plain part-select.
  assign w_dbl = {req, req};
  assign w_rot = w_dbl[ptr +: N_REQ];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_off   = '0;
    win_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = IDX_W'(i);
        win_vld = 1'b1;
      end
    end
  end

  assign win_idx = w_off + ptr;

endmodule : rr_pick8

// File: rtl/arbiter8_rr.sv
// Round-robin arbiter, 8 requesters, registered one-hot grant held until release.
// Optional forced revoke after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module arbiter8_rr
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  arbiter8_rr_if.slave  bus
);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_vld;

  rr_pick8 u_pick (
    .req     (bus.req),
    .ptr     (r_ptr),
    .win_idx (w_win_idx),
    .win_vld (w_win_vld)
  );

  a_max_hold_range: assert property (@(posedge clk) (MAX_HOLD >= 1) && (MAX_HOLD <= 255));

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt;
  logic       r_timeout;
  logic       w_hold_lim;

  // Counter holds completed grant cycles minus one, so the limit is MAX_HOLD-1.
  assign w_hold_lim = (r_hold_cnt == 8'(MAX_HOLD - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      unique case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
            r_state   <= GRANT;
            r_gnt     <= N_REQ'(1) << w_win_idx;
            r_gnt_idx <= w_win_idx;
            r_ptr     <= w_win_idx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (!bus.req[r_gnt_idx]) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (w_hold_lim) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_timeout <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
`endif
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_idx = r_gnt_idx;
  assign bus.busy    = (r_state == GRANT);
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule : arbiter8_rr

// File: tb/tb_arbiter8_rr.sv
// Scoreboard bench for arbiter8_rr; covers the timeout path when ARB_TIMEOUT_EN is defined.
module tb_arbiter8_rr;
  import arb_pkg::*;

  localparam int unsigned MAX_HOLD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  arbiter8_rr_if bus ();

  arbiter8_rr #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  logic m_busy;
  int   m_idx;
  int   m_ptr;
  int   m_cnt;
  logic m_to;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_idx  = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    m_to   = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r);
    bit found;
    int w;
    found = 0;
    w     = 0;
    m_to  = 1'b0;
    if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(m_ptr + k) % 8]) begin
          found = 1;
          w     = (m_ptr + k) % 8;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_idx  = w;
        m_ptr  = (w + 1) % 8;
        m_cnt  = 0;
      end
    end else if (!r[m_idx]) begin
      m_busy = 1'b0;
      m_idx  = 0;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_cnt == int'(MAX_HOLD) - 1) begin
        m_busy = 1'b0;
        m_idx  = 0;
        m_to   = 1'b1;
      end else begin
        m_cnt++;
      end
`endif
    end
  endtask

  task automatic step(input logic [7:0] r);
    exp_t e;
    @(negedge clk);
    bus.req = r;
    if (!rst_n) model_reset();
    else        model_edge(r);
    e.gnt  = m_busy ? 8'(1 << m_idx) : 8'h00;
    e.idx  = 3'(m_idx);
    e.busy = m_busy;
    e.to   = m_to;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("gnt",     32'(bus.gnt),     32'(e.gnt));
      check("gnt_idx", 32'(bus.gnt_idx), 32'(e.idx));
      check("busy",    32'(bus.busy),    32'(e.busy));
      check("timeout", 32'(bus.timeout), 32'(e.to));
    end
  endtask

  initial begin
    bus.req = 8'h00;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",  32'(bus.gnt),     32'h0);
    check("rst_idx",  32'(bus.gnt_idx), 32'h0);
    check("rst_busy", 32'(bus.busy),    32'h0);
    check("rst_to",   32'(bus.timeout), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pointer starts at 0, then wraps from 7 back to 0
    step(8'h81);
    check("first_gnt", 32'(bus.gnt), 32'h01);
    step(8'h80);
    check("dead_gnt", 32'(bus.gnt), 32'h00);
    step(8'h80);
    check("wrap_idx", 32'(bus.gnt_idx), 32'd7);
    step(8'h00);
    step(8'h00);

    // All requesting, each owner releasing after one grant cycle
    for (int i = 0; i < 9; i++) begin
      step(8'hFF);
      check("rr_order", 32'(bus.gnt_idx), 32'(i % 8));
      step(8'hFF & ~(8'h01 << (i % 8)));
      check("rr_dead_busy", 32'(bus.busy), 32'd0);
    end
    step(8'h00);

    // Owner 3 holds against requester 4: no preemption
    step(8'h08);
    for (int i = 0; i < 3; i++) begin
      step(8'h18);
      check("hold_gnt", 32'(bus.gnt), 32'h08);
    end
    step(8'h10);
    step(8'h10);
    check("handover_gnt", 32'(bus.gnt), 32'h10);
    step(8'h00);
    step(8'h00);

    // Asynchronous reset in the middle of a grant
    step(8'h20);
    check("pre_rst_gnt", 32'(bus.gnt), 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt",  32'(bus.gnt),     32'h0);
    check("async_idx",  32'(bus.gnt_idx), 32'h0);
    check("async_busy", 32'(bus.busy),    32'h0);
    check("async_to",   32'(bus.timeout), 32'h0);
    step(8'h21);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h21);
    check("post_rst_gnt", 32'(bus.gnt), 32'h01);
    step(8'h00);
    step(8'h00);

`ifdef ARB_TIMEOUT_EN
    // Forced revoke after MAX_HOLD cycles, then immediate re-grant
    step(8'h04);
    for (int i = 1; i < int'(MAX_HOLD); i++) begin
      step(8'h04);
      check("to_hold_gnt", 32'(bus.gnt), 32'h04);
    end
    step(8'h04);
    check("to_revoke_gnt", 32'(bus.gnt), 32'h00);
    check("to_pulse", 32'(bus.timeout), 32'd1);
    step(8'h04);
    check("to_regrant", 32'(bus.gnt), 32'h04);
    check("to_pulse_end", 32'(bus.timeout), 32'd0);
    // Release on the limit edge is a release, not a timeout
    for (int i = 1; i < int'(MAX_HOLD); i++) step(8'h04);
    step(8'h00);
    check("to_release_edge", 32'(bus.timeout), 32'd0);
    step(8'h00);
`else
    begin
      int to_seen;
      to_seen = 0;
      step(8'h04);
      for (int i = 0; i < 300; i++) begin
        step(8'h04);
        if (bus.timeout !== 1'b0) to_seen++;
      end
      check("long_hold_gnt", 32'(bus.gnt), 32'h04);
      check("long_hold_to_cnt", 32'(to_seen), 32'd0);
      step(8'h00);
      step(8'h00);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_arbiter8_rr
